// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: op codes and FSM states shared by the sequential ALU
package seq_alu_pkg;
    typedef enum logic [2:0] {ADD, SUB, AND, OR, SHL, SHR, MUL, RSVD} op_e;
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
endpackage

// File: rtl/seq_alu_addsub.sv
// seq_alu_addsub: WIDTH-bit adder with carry in/out and optional B inversion
module seq_alu_addsub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             inv_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);
    logic [WIDTH-1:0] bb;
    assign bb = inv_i ? ~b_i : b_i;
    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, bb} + {{WIDTH{1'b0}}, cin_i};
endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU; logic ops in one cycle, shifts bit-serial, MUL shift-add
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] hi,
    output logic             cout,
    output logic             zero
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);
    state_e state_q, state_d;
    op_e op_q, op_d, op_in;
    logic [WIDTH-1:0] mc_q, mc_d, y_q, y_d, hi_q, hi_d;
    logic cout_q, cout_d, zero_q, zero_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SHW-1:0] amt;
    logic [WIDTH-1:0] add_a, add_b, add_sum;
    logic add_inv, add_co;
    assign op_in = op_e'(op);
    assign amt = b[SHW-1:0];
    // MUL accumulates into hi through the same adder ADD/SUB use in IDLE
    assign add_a = (state_q == EXEC) ? hi_q : a;
    assign add_b = (state_q == EXEC) ? (y_q[0] ? mc_q : '0) : b;
    assign add_inv = (state_q == IDLE) && (op_in == SUB);
    seq_alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a_i(add_a),
        .b_i(add_b),
        .inv_i(add_inv),
        .cin_i(add_inv),
        .sum_o(add_sum),
        .cout_o(add_co)
    );
    always_comb begin
        state_d = state_q;
        op_d = op_q;
        mc_d = mc_q;
        y_d = y_q;
        hi_d = hi_q;
        cout_d = cout_q;
        zero_d = zero_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE: if (in_valid) begin
                op_d = op_in;
                mc_d = a;
                hi_d = '0;
                y_d = (op_in == ADD || op_in == SUB) ? add_sum :
                      (op_in == AND) ? (a & b) :
                      (op_in == OR) ? (a | b) :
                      (op_in == RSVD) ? '0 : a;
                cout_d = (op_in == ADD || op_in == SUB) && add_co;
                state_d = DONE;
                if (op_in == MUL) begin
                    y_d = b;
                    cnt_d = CW'(WIDTH);
                    state_d = EXEC;
                end else if ((op_in == SHL || op_in == SHR) && amt != '0) begin
                    cnt_d = CW'(amt);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                case (op_q)
                    SHL: begin
                        y_d = {y_q[WIDTH-2:0], 1'b0};
                        cout_d = y_q[WIDTH-1];
                    end
                    SHR: begin
                        y_d = {1'b0, y_q[WIDTH-1:1]};
                        cout_d = y_q[0];
                    end
                    default: begin
                        hi_d = {add_co, add_sum[WIDTH-1:1]};
                        y_d = {add_sum[0], y_q[WIDTH-1:1]};
                    end
                endcase
                cnt_d = cnt_q - 1'b1;
                state_d = (cnt_q == CW'(1)) ? DONE : EXEC;
            end
            default: state_d = out_ready ? IDLE : DONE;
        endcase
        if (state_d == DONE && state_q != DONE) zero_d = ~|{hi_d, y_d};
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q <= ADD;
            mc_q <= '0;
            y_q <= '0;
            hi_q <= '0;
            cout_q <= 1'b0;
            zero_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            op_q <= op_d;
            mc_q <= mc_d;
            y_q <= y_d;
            hi_q <= hi_d;
            cout_q <= cout_d;
            zero_q <= zero_d;
            cnt_q <= cnt_d;
        end
    end
    assign in_ready = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign y = y_q;
    assign hi = hi_q;
    assign cout = cout_q;
    assign zero = zero_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and random requests against an arithmetic reference model
module tb_seq_alu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [2:0] op = 3'd0;
    logic [7:0] a = 8'd0;
    logic [7:0] b = 8'd0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic [7:0] y;
    logic [7:0] hi;
    logic cout;
    logic zero;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    seq_alu #(.WIDTH(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .op(op),
        .a(a),
        .b(b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y(y),
        .hi(hi),
        .cout(cout),
        .zero(zero)
    );
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic run(input int o, input int ia, input int ib, input int hold);
        int amt, r, ey, eh, ec, ez, elat, lat;
        amt = ib % 8;
        ey = 0;
        eh = 0;
        ec = 0;
        elat = 1;
        case (o)
            0: begin r = ia + ib; ey = r & 255; ec = (r >> 8) & 1; end
            1: begin ey = (ia - ib) & 255; ec = (ia >= ib) ? 1 : 0; end
            2: ey = ia & ib;
            3: ey = ia | ib;
            4: begin ey = (ia << amt) & 255; ec = (amt != 0) ? ((ia >> (8 - amt)) & 1) : 0; elat = 1 + amt; end
            5: begin ey = ia >> amt; ec = (amt != 0) ? ((ia >> (amt - 1)) & 1) : 0; elat = 1 + amt; end
            6: begin r = ia * ib; ey = r & 255; eh = r >> 8; elat = 9; end
            default: ;
        endcase
        ez = (ey == 0 && eh == 0) ? 1 : 0;
        @(negedge clk);
        check("in_ready_before", 32'(in_ready), 1);
        in_valid = 1'b1;
        op = 3'(o);
        a = 8'(ia);
        b = 8'(ib);
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 3'($urandom);
        a = 8'($urandom);
        b = 8'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(elat));
        check("y", 32'(y), 32'(ey));
        check("hi", 32'(hi), 32'(eh));
        check("cout", 32'(cout), 32'(ec));
        check("zero", 32'(zero), 32'(ez));
        check("in_ready_busy", 32'(in_ready), 0);
        for (int i = 0; i < hold; i++) begin
            if (i == 1) begin
                in_valid = 1'b1;
                op = 3'($urandom);
            end
            if (i == 2) in_valid = 1'b0;
            @(posedge clk);
            #1;
            check("hold_valid", 32'(out_valid), 1);
            check("hold_y", 32'({hi, y, cout, zero}), 32'({eh[7:0], ey[7:0], ec[0], ez[0]}));
            check("hold_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("after_hs_valid", 32'(out_valid), 0);
        check("after_hs_ready", 32'(in_ready), 1);
    endtask
    initial begin
        #1000000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
    initial begin
        bit seen;
        in_valid = 1'b1;
        op = 3'd0;
        a = 8'h11;
        b = 8'h22;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_outs", 32'({hi, y, cout, zero}), 0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_rst", 32'({in_ready, out_valid}), 32'(2'b10));
        run(0, 8'hFF, 8'h01, 0);
        run(1, 8'h05, 8'h07, 0);
        run(1, 8'h07, 8'h07, 0);
        run(4, 8'h81, 8'h03, 0);
        run(5, 8'h81, 8'h01, 0);
        run(4, 8'h5A, 8'h00, 0);
        run(5, 8'hC3, 8'h18, 0);
        run(6, 8'hFF, 8'hFF, 0);
        run(6, 8'h00, 8'hFF, 0);
        run(2, 8'hF0, 8'h3C, 0);
        run(3, 8'h00, 8'h00, 0);
        run(7, 8'hAB, 8'hCD, 0);
        run(0, 8'h12, 8'h34, 5);
        run(6, 8'h0D, 8'h0B, 4);
        @(negedge clk);
        in_valid = 1'b1;
        op = 3'd6;
        a = 8'hA5;
        b = 8'h3C;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_mul_busy", 32'(out_valid), 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_valid", 32'(out_valid), 0);
        check("abort_outs", 32'({hi, y, cout, zero}), 0);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("no_result_after_abort", 32'(seen), 0);
        run(0, 8'h02, 8'h03, 0);
        for (int n = 0; n < 60; n++) begin
            run(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 5)) : 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width, >= 4.
REQ-002 SHALL have local parameter SHW = $clog2(WIDTH): shift-amount width taken from b.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 Port list, in this order:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request.
- op  input  3  operation code.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes result.
- y  output  WIDTH  result, low half for MUL.
- hi  output  WIDTH  high half for MUL; 0 otherwise.
- cout  output  1  carry / not-borrow / last bit shifted out.
- zero  output  1  result equals 0.

Function
REQ-005 SHALL accept a request on a rising edge when in_valid and in_ready are both 1; a, b and op are captured at that edge and later input changes are ignored.
REQ-006 SHALL drive in_ready = 1 only in state IDLE.
REQ-007 SHALL implement FSM IDLE -> (EXEC | DONE) -> DONE -> IDLE:
- accept of a single-cycle op -> DONE;
- accept of a shift with amount != 0, or of MUL -> EXEC;
- EXEC -> DONE when the iteration count expires;
- DONE with out_ready = 1 -> IDLE.
REQ-008 Op codes:
- 000 ADD: y = a+b, cout = carry out.
- 001 SUB: y = a-b, computed as a+~b+1; cout = 1 iff a >= b unsigned.
- 010 AND, 011 OR: cout = 0.
- 100 SHL, 101 SHR (logical): shift by b[SHW-1:0], one bit per EXEC cycle; cout = last bit shifted out; cout = 0 when the amount is 0.
- 110 MUL: unsigned shift-add, one multiplier bit per EXEC cycle, WIDTH EXEC cycles; {hi,y} = a*b; cout = 0.
- 111 reserved: y = 0, hi = 0, cout = 0, zero = 1.
REQ-009 Latency from accept edge to out_valid = 1:
- single-cycle ops: 1 cycle;
- shifts: 1 + amount cycles;
- MUL: WIDTH + 1 cycles.
REQ-010 SHALL drive out_valid = 1 only in DONE; y, hi, cout and zero SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-011 zero SHALL equal (y == 0) for non-MUL ops and ({hi,y} == 0) for MUL.
REQ-012 The handshake SHALL have no bypass: after the out handshake edge, in_ready rises in the following cycle; a request and a result are never both in flight.
REQ-013 Overflow SHALL wrap modulo 2^WIDTH for ADD and SUB; the shift amount SHALL wrap to b mod 2^SHW.

Reset
REQ-014 When rst_n = 0 at a rising edge, the block SHALL go to IDLE and clear out_valid, y, hi, cout, zero and all iteration counters; in_ready reads 1 from the next cycle.
REQ-015 Reset during EXEC or DONE SHALL abort the operation; no result is produced afterwards.
REQ-016 SHALL ignore in_valid while rst_n = 0.

Structure
REQ-017 Package seq_alu_pkg SHALL hold the op-code enum (ADD..RSVD) and the state enum (IDLE, EXEC, DONE).
REQ-018 Sub-module seq_alu_addsub (WIDTH-bit combinational adder with carry in/out and invert-B control) SHALL be shared by ADD, SUB and the MUL accumulate step.
REQ-019 The implementation SHALL contain no multiplier operator (*) and no variable-amount shift operator.

Verification (WIDTH = 8)
REQ-020 ADD a=FF b=01 -> y=00, cout=1, zero=1, out_valid exactly 1 cycle after accept.
REQ-021 SUB a=05 b=07 -> y=FE, cout=0, zero=0; SUB a=07 b=07 -> y=00, cout=1, zero=1.
REQ-022 SHL a=81 b=03 -> y=08, cout=0, latency 4. SHR a=81 b=01 -> y=40, cout=1, latency 2. SHL b=00 -> y=a, latency 1.
REQ-023 MUL a=FF b=FF -> hi=FE, y=01, latency 9. MUL a=00 b=FF -> zero=1.
REQ-024 Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0, and a new in_valid pulse is not accepted; the next request is accepted only after the handshake.
REQ-025 Reset mid-MUL: rst_n=0 on the 3rd EXEC cycle -> IDLE and out_valid=0 at the next edge, no result emitted, and a following ADD 02+03 returns y=05.
